pipeline_reg_chain: RTL

- Parametrised successor to the single-stage valid/ready pipeline register: a chain of STAGES elastic register slices.
- Data moves forward one slice per cycle whenever the next slice is empty or draining. Bubbles collapse under backpressure.
- Adds a synchronous flush and an occupancy count.
- Sits between datapath units that need a configurable retiming depth with lossless valid/ready flow control.

---
 rtl/pipeline_reg_chain.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pipeline_reg_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_reg_chain
// Description : STAGES-deep chain of elastic valid/ready register slices with
//               synchronous flush and a registered occupancy count.
//               Optional macro PIPE_CHAIN_SKID_EN adds a skid entry ahead of
//               slice 0 and registers in_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_reg_chain #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(STAGES+2)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(STAGES + 2);

  logic [STAGES-1:0]     v_q, v_d;
  logic [DATA_WIDTH-1:0] d_q [STAGES];
  logic [DATA_WIDTH-1:0] d_d [STAGES];
  logic [OCC_W-1:0]      occ_q, occ_d;

  logic [STAGES-1:0]     w_move;
  logic [STAGES-1:0]     w_load;
  logic                  w_accept;
  logic                  w_release;
  logic                  w_fill0;
  logic [DATA_WIDTH-1:0] w_src0;

`ifdef PIPE_CHAIN_SKID_EN
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  in_ready_q, in_ready_d;
`endif

  // Everything lives in one block so the ready ripple from out_ready back to
  // slice 0 is evaluated top-down without a cross-block loop.
  always_comb begin
    w_move    = '0;
    w_load    = '0;
    w_release = v_q[STAGES-1] && out_ready && !flush;
    w_move[STAGES-1] = w_release;
    for (int i = STAGES - 2; i >= 0; i--) begin
      w_move[i] = !flush && v_q[i] && (!v_q[i+1] || w_move[i+1]);
    end
    for (int i = 0; i < STAGES; i++) begin
      w_load[i] = !v_q[i] || w_move[i];
    end

`ifdef PIPE_CHAIN_SKID_EN
    in_ready     = rst_n && in_ready_q && !flush;
    w_accept     = in_valid && in_ready;
    w_fill0      = !flush && w_load[0] && (skid_valid_q || w_accept);
    w_src0       = skid_valid_q ? skid_data_q : in_data;
    skid_data_d  = (w_accept && !w_load[0]) ? in_data : skid_data_q;
    if (flush) begin
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      skid_valid_d = !w_fill0;
    end else begin
      skid_valid_d = w_accept && !w_load[0];
    end
    in_ready_d   = !flush && !skid_valid_d;
`else
    in_ready     = rst_n && w_load[0] && !flush;
    w_accept     = in_valid && in_ready;
    w_fill0      = w_accept;
    w_src0       = in_data;
`endif

    v_d[0] = !flush && (w_fill0 || (v_q[0] && !w_move[0]));
    d_d[0] = w_fill0 ? w_src0 : d_q[0];
    for (int i = 1; i < STAGES; i++) begin
      v_d[i] = !flush && (w_move[i-1] || (v_q[i] && !w_move[i]));
      d_d[i] = w_move[i-1] ? d_q[i-1] : d_q[i];
    end

    if (flush) begin
      occ_d = '0;
    end else if (w_accept && !w_release) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!w_accept && w_release) begin
      occ_d = occ_q - OCC_W'(1);
    end else begin
      occ_d = occ_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d_q[i] <= '0;
      end
`ifdef PIPE_CHAIN_SKID_EN
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
`endif
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int i = 0; i < STAGES; i++) begin
        d_q[i] <= d_d[i];
      end
`ifdef PIPE_CHAIN_SKID_EN
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
`endif
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_data  = d_q[STAGES-1];
  assign occupancy = occ_q;

endmodule
`default_nettype wire
